residual_encoder: RTL and testbench

Consumes the per-block header_residual_reg (32 RGBA pixels plus per-channel min/max) produced by the min/max header stage. Derives the per-channel residual width and skip flags, and selects compressed or raw mode. Emits a two-beat header followed by one variable-width residual beat per pixel on a valid/ready stream, which feeds the downstream bit packer.

---
 rtl/residual_encoder_pkg.sv | 54 +++++
 rtl/residual_encoder_channel_width_calc.sv | 24 ++
 rtl/residual_encoder.sv | 173 +++++++++++++++++
 tb/tb_residual_encoder.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/residual_encoder_pkg.sv
// Shared types and constants for the residual encoder stage.
package residual_encoder_pkg;

  localparam int NUM_PIXELS = 32;
  localparam int NUM_CH     = 4;
  localparam int CH_W       = 8;
  localparam int HDR1_NBITS = 27;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CALC = 3'd1,
    S_HDR0 = 3'd2,
    S_HDR1 = 3'd3,
    S_PIX  = 3'd4
  } enc_state_e;

  typedef enum logic [1:0] {
    K_HDR0 = 2'd0,
    K_HDR1 = 2'd1,
    K_PIX  = 2'd2
  } enc_kind_e;

  typedef struct packed {
    logic [3:0] bits;
    logic       skip;
  } ch_cfg_t;

  // Channel order packs as {a,b,g,r}: channel 0 (r) sits in the low byte.
  typedef struct packed {
    logic [CH_W-1:0] a;
    logic [CH_W-1:0] b;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] r;
  } ch_vals_t;

  typedef ch_vals_t pixel_t;

  typedef struct packed {
    ch_vals_t   vals;
    logic [3:0] bits_required;
    logic       skip_a;
    logic       skip_b;
    logic       skip_g;
    logic       skip_r;
  } min_values_t;

  typedef struct packed {
    pixel_t [NUM_PIXELS-1:0] pixels;
    min_values_t             min_values;
    ch_vals_t                max_values;
    logic                    compressable;
  } header_residual_reg_t;

endpackage

// File: rtl/residual_encoder_channel_width_calc.sv
// Per-channel range, residual width, skip and inconsistency detection.
module channel_width_calc
  import residual_encoder_pkg::*;
(
  input  logic [CH_W-1:0] min_i,
  input  logic [CH_W-1:0] max_i,
  output logic [CH_W-1:0] range_o,
  output logic [3:0]      bits_o,
  output logic            skip_o,
  output logic            bad_o
);

  // Width is the position of the highest set bit of the range, plus one.
  always_comb begin
    range_o = max_i - min_i;
    bad_o   = (max_i < min_i);
    skip_o  = (range_o == '0);
    bits_o  = 4'd0;
    for (int b = 0; b < CH_W; b++) begin
      if (range_o[b]) bits_o = 4'(b + 1);
    end
  end

endmodule

// File: rtl/residual_encoder.sv
// Residual encoder: turns one header_residual_reg block into a two-beat
// header followed by one variable-width residual beat per pixel.
module residual_encoder
  import residual_encoder_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  header_residual_reg_t hr_reg,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           out_kind,
  output logic [31:0]          out_data,
  output logic [5:0]           out_nbits,
  output logic                 out_last,
  output logic                 busy
);

  enc_state_e                     state_q, state_d;
  logic [4:0]                     pix_idx_q, pix_idx_d;
  header_residual_reg_t           blk_q;
  ch_cfg_t [NUM_CH-1:0]           cfg_q, cfg_d;
  logic                           comp_q, comp_d;
  logic [5:0]                     total_q, total_d;

  logic [NUM_CH-1:0][CH_W-1:0]    rng_w;
  logic [NUM_CH-1:0][3:0]         bits_w;
  logic [NUM_CH-1:0]              skip_w, bad_w;
  logic [31:0]                    mins_w, maxs_w, pix_w, pix_pack;
  logic                           unused_hdr;

  // Keep only the low n bits of a residual.
  function automatic logic [CH_W-1:0] trunc_bits(input logic [CH_W-1:0] v, input logic [3:0] n);
    logic [CH_W:0] m;
    m = (9'd1 << n) - 9'd1;
    return v & m[CH_W-1:0];
  endfunction

  assign mins_w = blk_q.min_values.vals;
  assign maxs_w = blk_q.max_values;
  assign pix_w  = blk_q.pixels[pix_idx_q];

  // Upstream width/skip hints are recomputed here, so they are deliberately dropped.
  assign unused_hdr = ^{blk_q.min_values.bits_required, blk_q.min_values.skip_a,
                        blk_q.min_values.skip_b, blk_q.min_values.skip_g,
                        blk_q.min_values.skip_r, rng_w};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    channel_width_calc u_calc (
      .min_i   (mins_w[c*CH_W +: CH_W]),
      .max_i   (maxs_w[c*CH_W +: CH_W]),
      .range_o (rng_w[c]),
      .bits_o  (bits_w[c]),
      .skip_o  (skip_w[c]),
      .bad_o   (bad_w[c])
    );
  end

  // Block configuration: total width and mode, with raw mode forcing full-width channels.
  always_comb begin
    logic any_bad;
    any_bad = 1'b0;
    total_d = 6'd0;
    for (int c = 0; c < NUM_CH; c++) begin
      cfg_d[c].bits = bits_w[c];
      cfg_d[c].skip = skip_w[c];
      total_d       = total_d + {2'b00, bits_w[c]};
      any_bad       = any_bad | bad_w[c];
    end
    comp_d = blk_q.compressable && !any_bad && (total_d < 6'd32);
    if (!comp_d) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cfg_d[c].bits = 4'd8;
        cfg_d[c].skip = 1'b0;
      end
      total_d = 6'd32;
    end
  end

  // Pack non-skipped residuals of the current pixel LSB-first in r,g,b,a order.
  always_comb begin
    logic [5:0]      pos;
    logic [CH_W-1:0] diff;
    pix_pack = '0;
    pos      = 6'd0;
    for (int c = 0; c < NUM_CH; c++) begin
      diff = pix_w[c*CH_W +: CH_W] - mins_w[c*CH_W +: CH_W];
      if (!cfg_q[c].skip) begin
        pix_pack = pix_pack | ({24'd0, trunc_bits(diff, cfg_q[c].bits)} << pos);
        pos      = pos + {2'b00, cfg_q[c].bits};
      end
    end
  end

  // Beat sequencing: a beat only advances on an accepted handshake.
  always_comb begin
    state_d   = state_q;
    pix_idx_d = pix_idx_q;
    case (state_q)
      S_IDLE: if (in_valid) state_d = S_CALC;
      S_CALC: state_d = S_HDR0;
      S_HDR0: if (out_ready) state_d = S_HDR1;
      S_HDR1: if (out_ready) begin
        state_d   = (total_q == 6'd0) ? S_IDLE : S_PIX;
        pix_idx_d = 5'd0;
      end
      S_PIX: if (out_ready) begin
        if (pix_idx_q == 5'(NUM_PIXELS - 1)) state_d = S_IDLE;
        else pix_idx_d = pix_idx_q + 5'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output beat is a pure function of state and registered block data, so it holds while stalled.
  always_comb begin
    out_valid = 1'b0;
    out_kind  = K_HDR0;
    out_data  = 32'd0;
    out_nbits = 6'd0;
    out_last  = 1'b0;
    case (state_q)
      S_HDR0: begin
        out_valid = 1'b1;
        out_data  = mins_w;
        out_nbits = 6'd32;
      end
      S_HDR1: begin
        out_valid = 1'b1;
        out_kind  = K_HDR1;
        out_data  = {5'd0, total_q, comp_q,
                     cfg_q[3].bits, cfg_q[2].bits, cfg_q[1].bits, cfg_q[0].bits,
                     cfg_q[3].skip, cfg_q[2].skip, cfg_q[1].skip, cfg_q[0].skip};
        out_nbits = 6'(HDR1_NBITS);
        out_last  = (total_q == 6'd0);
      end
      S_PIX: begin
        out_valid = 1'b1;
        out_kind  = K_PIX;
        out_data  = comp_q ? pix_pack : pix_w;
        out_nbits = total_q;
        out_last  = (pix_idx_q == 5'(NUM_PIXELS - 1));
      end
      default: ;
    endcase
  end

  assign in_ready = (state_q == S_IDLE);
  assign busy     = (state_q != S_IDLE);

  // Control state with asynchronous reset; a mid-block reset discards the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pix_idx_q <= 5'd0;
    end else begin
      state_q   <= state_d;
      pix_idx_q <= pix_idx_d;
    end
  end

  // Block data capture and per-block configuration registered during CALC.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) blk_q <= hr_reg;
    if (state_q == S_CALC) begin
      cfg_q   <= cfg_d;
      comp_q  <= comp_d;
      total_q <= total_d;
    end
  end

endmodule

// File: tb/tb_residual_encoder.sv
// Directed bench for residual_encoder with a beat-list reference model.
module tb_residual_encoder;
  import residual_encoder_pkg::*;

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] data;
    logic [5:0]  nbits;
    logic        last;
  } beat_t;

  logic                 clk = 1'b0;
  logic                 rst_n, in_valid, in_ready, out_valid, out_ready, out_last, busy;
  header_residual_reg_t hr_reg, h;
  logic [1:0]           out_kind;
  logic [31:0]          out_data, last_hdr1;
  logic [5:0]           out_nbits;

  beat_t exp_q[$];
  beat_t mdl_q[$];
  int    checks = 0;
  int    errors = 0;
  int    ncyc;

  always #5 clk = ~clk;

  residual_encoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .hr_reg(hr_reg),
    .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind), .out_data(out_data),
    .out_nbits(out_nbits), .out_last(out_last), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic int chv(input logic [31:0] v, input int c);
    return int'(v >> (8 * c)) & 255;
  endfunction

  // Reference: expected beat list of a block, straight from the encoding rules.
  task automatic model_build(input header_residual_reg_t b);
    int    mn[4], mx[4], bits[4], skip[4];
    int    total, pos;
    bit    bad, comp;
    longint d, hdr1, res;
    beat_t bt;
    mdl_q.delete();
    bad = 0; total = 0;
    for (int c = 0; c < 4; c++) begin
      mn[c] = chv(b.min_values.vals, c);
      mx[c] = chv(b.max_values, c);
      if (mx[c] < mn[c]) bad = 1;
      bits[c] = $clog2(((mx[c] - mn[c]) & 255) + 1);
      skip[c] = (bits[c] == 0);
      total += bits[c];
    end
    comp = b.compressable && !bad && total < 32;
    if (!comp) begin
      for (int c = 0; c < 4; c++) begin bits[c] = 8; skip[c] = 0; end
      total = 32;
    end
    bt.kind = 2'd0; bt.data = b.min_values.vals; bt.nbits = 6'd32; bt.last = 0;
    mdl_q.push_back(bt);
    hdr1 = 0;
    for (int c = 0; c < 4; c++) hdr1 += longint'(skip[c]) * (1 << c) + longint'(bits[c]) * (16 << (4 * c));
    hdr1 += longint'(comp) * (1 << 20) + longint'(total) * (1 << 21);
    bt.kind = 2'd1; bt.data = hdr1[31:0]; bt.nbits = 6'd27; bt.last = (total == 0);
    mdl_q.push_back(bt);
    if (total == 0) return;
    for (int p = 0; p < 32; p++) begin
      if (comp) begin
        d = 0; pos = 0;
        for (int c = 0; c < 4; c++) begin
          if (!skip[c]) begin
            res = ((chv(b.pixels[p], c) - mn[c]) & 255) % (1 << bits[c]);
            d += res << pos;
            pos += bits[c];
          end
        end
      end else begin
        d = longint'(b.pixels[p]);
      end
      bt.kind = 2'd2; bt.data = d[31:0]; bt.nbits = 6'(total); bt.last = (p == 31);
      mdl_q.push_back(bt);
    end
  endtask

  // Every valid output cycle is compared with the head of the expected list.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {30'd0, out_kind}, 32'hFFFF_FFFF);
      end else begin
        chk("beat_kind", {30'd0, out_kind}, {30'd0, exp_q[0].kind});
        chk("beat_data", out_data, exp_q[0].data);
        chk("beat_nbits", {26'd0, out_nbits}, {26'd0, exp_q[0].nbits});
        chk("beat_last", {31'd0, out_last}, {31'd0, exp_q[0].last});
        if (out_ready) begin
          if (out_kind == 2'd1) last_hdr1 = out_data;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic send(input header_residual_reg_t b);
    int n = 0;
    @(posedge clk); #1;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    model_build(b);
    foreach (mdl_q[i]) exp_q.push_back(mdl_q[i]);
    hr_reg = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("lat_calc_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("lat_hdr0_valid", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin @(posedge clk); #1; n++; end
    chk("block_done", {31'd0, n < 300}, 32'd1);
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic wait_pix(input logic [31:0] v);
    int n = 0;
    while (!(out_valid && out_kind == 2'd2 && out_data == v) && n < 100) begin @(posedge clk); #1; n++; end
    chk("reach_pix_beat", {31'd0, n < 100}, 32'd1);
  endtask

  task automatic mk_flat(output header_residual_reg_t b);
    b = '0;
    for (int i = 0; i < 32; i++) b.pixels[i] = 32'hFF1E140A;
    b.min_values.vals = 32'hFF1E140A;
    b.max_values      = 32'hFF1E140A;
    b.compressable    = 1'b1;
  endtask

  task automatic mk_ramp(output header_residual_reg_t b);
    b = '0;
    for (int i = 0; i < 32; i++) b.pixels[i].r = 8'(i);
    b.max_values.r = 8'd31;
    b.compressable = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; hr_reg = '0; last_hdr1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_out_kind", {30'd0, out_kind}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_nbits", {26'd0, out_nbits}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

    // Test 1: flat block, every channel skipped.
    mk_flat(h);
    model_build(h);
    chk("pin1_size", mdl_q.size(), 32'd2);
    chk("pin1_hdr0", mdl_q[0].data, 32'hFF1E140A);
    chk("pin1_hdr1", mdl_q[1].data, 32'h0010000F);
    send(h); wait_done(ncyc);
    chk("t1_hdr1_dut", last_hdr1, 32'h0010000F);

    // Test 2: red ramp, 5-bit residuals.
    mk_ramp(h);
    model_build(h);
    chk("pin2_hdr1", mdl_q[1].data, 32'h00B0005E);
    chk("pin2_pix31", mdl_q[33].data, 32'd31);
    send(h); wait_done(ncyc);
    chk("t2_hdr1_dut", last_hdr1, 32'h00B0005E);
    chk("t2_cycles", ncyc, 32'd34);

    // Test 3: full-range channels fall back to raw.
    h = '0;
    for (int i = 0; i < 32; i++) begin
      h.pixels[i].r = (i % 2) ? 8'd255 : 8'd0;
      h.pixels[i].g = 8'(i * 8);
      h.pixels[i].b = 8'(255 - i * 8);
      h.pixels[i].a = 8'(3 + i * 7);
    end
    h.min_values.vals = {8'd3, 8'd7, 8'd0, 8'd0};
    h.max_values      = {8'd220, 8'd255, 8'd248, 8'd255};
    h.compressable    = 1'b1;
    model_build(h);
    chk("pin3_hdr1", mdl_q[1].data, 32'h04088880);
    chk("pin3_pix1", mdl_q[3].data, 32'h0AF708FF);
    send(h); wait_done(ncyc);
    chk("t3_hdr1_dut", last_hdr1, 32'h04088880);

    // Test 4: stall at pixel beat 7.
    mk_ramp(h);
    send(h);
    wait_pix(32'd7);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_data", out_data, 32'd7);
      chk("stall_nbits", {26'd0, out_nbits}, 32'd5);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("after_stall_data", out_data, 32'd8);
    wait_done(ncyc);

    // Test 5: reset in the middle of pixel beat 12.
    mk_ramp(h);
    send(h);
    wait_pix(32'd12);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_idle_valid", {31'd0, out_valid}, 32'd0);
    mk_flat(h);
    send(h); wait_done(ncyc);
    chk("t5_hdr1_dut", last_hdr1, 32'h0010000F);

    // Test 6: inverted red min/max forces raw mode.
    h = '0;
    for (int i = 0; i < 32; i++) h.pixels[i] = 32'h01020300 + 32'(i);
    h.min_values.vals.r = 8'd50;
    h.max_values.r      = 8'd40;
    h.compressable      = 1'b1;
    send(h); wait_done(ncyc);
    chk("t6_comp_bit", {31'd0, last_hdr1[20]}, 32'd0);
    chk("t6_hdr1_dut", last_hdr1, 32'h04088880);

    // Test 7: mixed widths with one skipped channel.
    h = '0;
    for (int i = 0; i < 32; i++) begin
      h.pixels[i].r = 8'(5 + i % 4);
      h.pixels[i].g = 8'd77;
      h.pixels[i].b = 8'(100 + i * 3);
      h.pixels[i].a = 8'(16 + i % 16);
    end
    h.min_values.vals = {8'd16, 8'd100, 8'd77, 8'd5};
    h.max_values      = {8'd31, 8'd200, 8'd77, 8'd8};
    h.compressable    = 1'b1;
    model_build(h);
    chk("pin7_hdr1", mdl_q[1].data, 32'h01B47022);
    chk("pin7_pix1", mdl_q[3].data, 32'h0000020D);
    send(h); wait_done(ncyc);
    chk("t7_hdr1_dut", last_hdr1, 32'h01B47022);

    // Test 8: upstream marks the block not compressable.
    mk_ramp(h);
    h.compressable = 1'b0;
    send(h); wait_done(ncyc);
    chk("t8_hdr1_dut", last_hdr1, 32'h04088880);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
